// File: rtl/inverse_pkg.sv
// Shared types, dimensions and the round/saturate helper for the fixed-point matrix datapath.
package inverse_pkg;

    localparam int unsigned N      = 6;
    localparam int unsigned W      = 36;
    localparam int unsigned FRAC   = 18;
    localparam int unsigned PROD_W = 2 * W;
    localparam int unsigned SUM_W  = 2 * W + 3;
    localparam int unsigned ROW_W  = $clog2(N);

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t [N-1:0]        row_t;
    typedef elem_t [N-1:0][N-1:0] matrix_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1) << (FRAC - 1);
    localparam logic signed [SUM_W-1:0] ELEM_MAX = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ELEM_MIN = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};

    // Round half up at the FRAC boundary, then clamp to the element range.
    function automatic elem_t round_sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] r;
        r = s + HALF_LSB;
        r = r >>> FRAC;
        if (r > ELEM_MAX)
            return ELEM_MAX[W-1:0];
        else if (r < ELEM_MIN)
            return ELEM_MIN[W-1:0];
        else
            return r[W-1:0];
    endfunction

endpackage

// File: rtl/dot_product_6.sv
// One output column of one result row: registered products, registered adder tree,
// combinational round/saturate on the registered sum.
module dot_product_6
    import inverse_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  row_t  a_row,
    input  row_t  b_col,
    output elem_t y
);

    logic signed [PROD_W-1:0] prod [N];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  acc;

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < N; k++)
            acc = acc + {{(SUM_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++)
                prod[k] <= '0;
            sum <= '0;
        end else if (en) begin
            for (int unsigned k = 0; k < N; k++)
                prod[k] <= PROD_W'($signed(a_row[k])) * PROD_W'($signed(b_col[k]));
            sum <= acc;
        end
    end

    assign y = round_sat(sum);

endmodule

// File: rtl/mat_mult_6x6.sv
// 6x6 signed Q17.18 matrix multiplier: one result row issued per cycle, whole matrix committed at once.
module mat_mult_6x6
    import inverse_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    start,
    input  matrix_t mat_mult_dataa,
    input  matrix_t mat_mult_datab,
    output matrix_t mat_mult_result,
    output logic    busy,
    output logic    done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_t           state;
    matrix_t          a_lat;
    matrix_t          b_lat;
    matrix_t          b_cols;
    matrix_t          buffer;
    row_t             row_out;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_s1;
    logic [ROW_W-1:0] row_s2;
    logic             valid_s1;
    logic             valid_s2;

    always_comb begin
        b_cols = '0;
        for (int unsigned c = 0; c < N; c++)
            for (int unsigned k = 0; k < N; k++)
                b_cols[c][k] = b_lat[k][c];
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        dot_product_6 u_dot (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .a_row (a_lat[row]),
            .b_col (b_cols[c]),
            .y     (row_out[c])
        );
    end

    // Row tags travel alongside the two datapath stages so the buffer write lands on the right row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            row_s1   <= '0;
            row_s2   <= '0;
            buffer   <= '0;
        end else if (en) begin
            valid_s1 <= (state == ISSUE);
            row_s1   <= row;
            valid_s2 <= valid_s1;
            row_s2   <= row_s1;
            if (valid_s2)
                buffer[row_s2] <= row_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            a_lat           <= '0;
            b_lat           <= '0;
            row             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mat_mult_result <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    // busy is still high in the done cycle, so a start there is dropped
                    if (start && !busy) begin
                        a_lat <= mat_mult_dataa;
                        b_lat <= mat_mult_datab;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (row == LAST_ROW)
                        state <= DRAIN;
                    else
                        row <= row + 1'b1;
                end
                DRAIN: begin
                    if (valid_s2 && row_s2 == LAST_ROW)
                        state <= COMMIT;
                end
                COMMIT: begin
                    mat_mult_result <= buffer;
                    done            <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_6x6.sv
// Scoreboard bench for mat_mult_6x6: expected matrices queued at start, compared at done.
module tb_mat_mult_6x6;

    typedef logic signed [35:0] el_t;
    typedef el_t [5:0][5:0]     mat_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic start;
    mat_t dataa;
    mat_t datab;
    mat_t result;
    logic busy;
    logic done;

    int   checks = 0;
    int   errors = 0;
    mat_t sb[$];

    always #5 clk = ~clk;

    mat_mult_6x6 dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .start           (start),
        .mat_mult_dataa  (dataa),
        .mat_mult_datab  (datab),
        .mat_mult_result (result),
        .busy            (busy),
        .done            (done)
    );

    function automatic mat_t model(input mat_t a, input mat_t b);
        logic signed [74:0] s;
        logic signed [74:0] x;
        logic signed [74:0] y;
        mat_t c;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                s = '0;
                for (int k = 0; k < 6; k++) begin
                    x = {{39{a[i][k][35]}}, a[i][k]};
                    y = {{39{b[k][j][35]}}, b[k][j]};
                    s = s + x * y;
                end
                s = s + 75'sd131072;
                s = s >>> 18;
                if (s > 75'sd34359738367)
                    c[i][j] = 36'h7FFFFFFFF;
                else if (s < -75'sd34359738368)
                    c[i][j] = 36'h800000000;
                else
                    c[i][j] = s[35:0];
            end
        return c;
    endfunction

    function automatic int first_diff(input mat_t a, input mat_t b);
        for (int i = 0; i < 36; i++)
            if (a[i/6][i%6] !== b[i/6][i%6])
                return i;
        return 0;
    endfunction

    task automatic rand_mat(output mat_t m);
        logic [31:0] t;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                t = $urandom;
                m[i][j] = {{14{t[21]}}, t[21:0]};
            end
    endtask

    task automatic ident(output mat_t m, input el_t d);
        m = '0;
        for (int i = 0; i < 6; i++)
            m[i][i] = d;
    endtask

    // Drives start so it is sampled at the next posedge (edge 0), then scrambles the operand inputs.
    task automatic start_op(input mat_t a, input mat_t b, input bit push);
        mat_t junk;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        if (push)
            sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        rand_mat(junk);
        dataa = junk;
        rand_mat(junk);
        datab = junk;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        dataa = '0;
        datab = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got %h exp 0", result[0][0]);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_identity;
        mat_t a;
        mat_t b;
        mat_t e;
        int   cyc;
        int   d;
        ident(a, 36'h000040000);
        rand_mat(b);
        start_op(a, b, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL identity_busy got %b exp 1", busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL identity_latency got %0d exp 9", cyc);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL identity_busy_in_done got %b exp 1", busy);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e || result !== b) begin
            errors++;
            d = first_diff(result, b);
            $display("FAIL identity_result [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], b[d/6][d%6]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_sign;
        mat_t a;
        mat_t b;
        mat_t e;
        mat_t k;
        int   cyc;
        int   d;
        ident(a, 36'hFFFFC0000);
        ident(b, 36'h000040000);
        ident(k, 36'hFFFFC0000);
        start_op(a, b, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL sign_latency got %0d exp 9", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e || result !== k) begin
            errors++;
            d = first_diff(result, k);
            $display("FAIL sign_result [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], k[d/6][d%6]);
        end
        @(posedge clk);
    endtask

    task automatic test_saturation;
        mat_t a;
        mat_t b;
        mat_t e;
        int   cyc;
        int   d;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++) begin
                    a[i][j] = (pass == 0) ? 36'h7FFFFFFFF : 36'h800000000;
                    b[i][j] = 36'h7FFFFFFFF;
                end
            start_op(a, b, 1'b1);
            wait_done(cyc);
            checks++;
            if (cyc !== 9) begin
                errors++;
                $display("FAIL sat%0d_latency got %0d exp 9", pass, cyc);
            end
            e = sb.pop_front();
            checks++;
            if (result !== e) begin
                errors++;
                d = first_diff(result, e);
                $display("FAIL sat%0d_result [%0d][%0d] got %h exp %h", pass, d/6, d%6, result[d/6][d%6], e[d/6][d%6]);
            end
            checks++;
            if (result[3][2] !== ((pass == 0) ? 36'h7FFFFFFFF : 36'h800000000)) begin
                errors++;
                $display("FAIL sat%0d_elem got %h", pass, result[3][2]);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_rounding;
        mat_t a;
        mat_t b;
        mat_t e;
        int   cyc;
        int   d;
        a = '0;
        b = '0;
        a[0][0] = 36'h000000001;
        b[0][0] = 36'h000020000;
        start_op(a, b, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL round_latency got %0d exp 9", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e) begin
            errors++;
            d = first_diff(result, e);
            $display("FAIL round_result [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e[d/6][d%6]);
        end
        checks++;
        if (result[0][0] !== 36'h000000001) begin
            errors++;
            $display("FAIL round_elem got %h exp 000000001", result[0][0]);
        end
        @(posedge clk);
    endtask

    task automatic test_stall;
        mat_t a;
        mat_t b;
        mat_t e;
        int   cyc;
        int   d;
        rand_mat(a);
        rand_mat(b);
        start_op(a, b, 1'b1);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
            if (i == 2)
                en = 1'b0;
            if (i == 5)
                en = 1'b1;
        end
        en = 1'b1;
        checks++;
        if (cyc !== 12) begin
            errors++;
            $display("FAIL stall_latency got %0d exp 12", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e) begin
            errors++;
            d = first_diff(result, e);
            $display("FAIL stall_result [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e[d/6][d%6]);
        end
        @(posedge clk);
    endtask

    task automatic test_busy;
        mat_t a;
        mat_t b;
        mat_t e;
        int   cyc;
        int   d;
        int   extra;
        rand_mat(a);
        rand_mat(b);
        start_op(a, b, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dataa = b;
        datab = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL busy_latency got %0d exp 5", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e) begin
            errors++;
            d = first_diff(result, e);
            $display("FAIL busy_result [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e[d/6][d%6]);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done)
                extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_extra_done got %0d exp 0", extra);
        end
    endtask

    task automatic test_abort;
        mat_t a;
        mat_t b;
        int   extra;
        ident(a, 36'h000040000);
        rand_mat(b);
        start_op(a, b, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got r00=%h busy=%b done=%b exp 0 0 0", result[0][0], busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done)
                extra++;
        end
        checks++;
        if (extra !== 0 || result !== '0) begin
            errors++;
            $display("FAIL abort_no_done got %0d dones r00=%h exp 0", extra, result[0][0]);
        end
    endtask

    task automatic test_back_to_back;
        mat_t a;
        mat_t b;
        mat_t e1;
        mat_t e;
        int   cyc;
        int   d;
        rand_mat(a);
        rand_mat(b);
        start_op(a, b, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp 9", cyc);
        end
        e1 = sb.pop_front();
        checks++;
        if (result !== e1) begin
            errors++;
            d = first_diff(result, e1);
            $display("FAIL b2b_result1 [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e1[d/6][d%6]);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_done got busy=%b exp 0", busy);
        end
        rand_mat(a);
        rand_mat(b);
        start_op(a, b, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (result !== e1) begin
            errors++;
            d = first_diff(result, e1);
            $display("FAIL b2b_hold [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e1[d/6][d%6]);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL b2b_latency2 got %0d exp 5", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e) begin
            errors++;
            d = first_diff(result, e);
            $display("FAIL b2b_result2 [%0d][%0d] got %h exp %h", d/6, d%6, result[d/6][d%6], e[d/6][d%6]);
        end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sign();
        test_saturation();
        test_rounding();
        test_stall();
        test_busy();
        test_abort();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
